btle_rx_pdu_reader: RTL and testbench

- Drains a received PDU out of the receiver's PDU octet memory after each decode and presents it as a byte stream with a valid/ready handshake.
- It is the reader end of the receiver's PDU memory interface: it drives the octet read address and consumes the read data.
- It sits between the receive PHY and the link-layer or host logic.

---
 rtl/btle_rx_pdu_reader.sv | 176 +++++++++++++++++
 tb/tb_btle_rx_pdu_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btle_rx_pdu_reader.sv
// btle_rx_pdu_reader
//
// Drains a received PDU out of the receiver's PDU octet memory after each
// decode and presents it as a byte stream with a valid/ready handshake.
// Reads are issued to a memory with one cycle of registered read latency.
// The returning octets land in a 2-entry output FIFO, whose head drives the stream.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   decode_end          1-cycle pulse: PDU memory and status complete
//   crc_ok              CRC result, valid with decode_end
//   payload_length      payload octet count, valid with decode_end
//   pdu_octet_mem_addr  PDU memory read address
//   pdu_octet_mem_data  PDU memory read data (1 clk after address)
//   m_octet/m_valid/m_ready/m_last  output byte stream
//   m_crc_ok            latched CRC result of the PDU being streamed
//   m_truncated         latched flag: PDU length was clamped to memory depth
//   busy                PDU accepted and not yet fully handed off
//   drop_count          saturating count of dropped decode_end events
//
// Optional build macro: BTLE_RX_PDU_READER_CRC_FILTER_EN
//   When defined, CRC-bad PDUs are dropped instead of streamed.

module btle_rx_pdu_reader #(
  parameter int PDU_ADDR_BIT_WIDTH       = 6,
  parameter int PAYLOAD_LENGTH_BIT_WIDTH = 7,
  parameter int DROP_COUNT_BIT_WIDTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                decode_end,
  input  logic                                crc_ok,
  input  logic [PAYLOAD_LENGTH_BIT_WIDTH-1:0] payload_length,
  output logic [PDU_ADDR_BIT_WIDTH-1:0]       pdu_octet_mem_addr,
  input  logic [7:0]                          pdu_octet_mem_data,
  output logic [7:0]                          m_octet,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                m_last,
  output logic                                m_crc_ok,
  output logic                                m_truncated,
  output logic                                busy,
  output logic [DROP_COUNT_BIT_WIDTH-1:0]     drop_count
);

  // Octet counts go up to 2^PDU_ADDR_BIT_WIDTH, so they need one extra bit.
  localparam int CNT_W = PDU_ADDR_BIT_WIDTH + 1;
  localparam int LEN_W = PAYLOAD_LENGTH_BIT_WIDTH + 1;
  localparam int CMP_W = (LEN_W > CNT_W) ? LEN_W : CNT_W;
  localparam logic [CMP_W-1:0] MAX_TOTAL = CMP_W'(2 ** PDU_ADDR_BIT_WIDTH);

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [DROP_COUNT_BIT_WIDTH-1:0] sat_inc(
    input logic [DROP_COUNT_BIT_WIDTH-1:0] v
  );
    if (&v) return v;
    return v + DROP_COUNT_BIT_WIDTH'(1);
  endfunction

  // Returns {truncated, total}; total = payload + 2 header octets, clamped
  // to the memory depth.
  function automatic logic [CNT_W:0] clamp_len(
    input logic [PAYLOAD_LENGTH_BIT_WIDTH-1:0] plen
  );
    logic [CMP_W-1:0] raw;
    raw = CMP_W'(plen) + CMP_W'(2);
    if (raw > MAX_TOTAL) return {1'b1, CNT_W'(MAX_TOTAL)};
    return {1'b0, CNT_W'(raw)};
  endfunction

  state_t                         state_q, state_d;
  logic                           crc_reject, accept, drop, pop, issue;
  logic                           last_issue, done;
  logic [1:0]                     occ_eff;
  logic [CNT_W:0]                 len_info;
  logic [CNT_W-1:0]               total_q, rd_ptr_p0;
  logic [PDU_ADDR_BIT_WIDTH-1:0]  addr_hold;
  logic                           crc_q, trunc_q;
  logic                           vld_p1, last_p1;
  logic [7:0]                     fifo_data [2];
  logic [1:0]                     fifo_last;
  logic                           wr_idx, rd_idx;
  logic [1:0]                     fifo_cnt;
  logic [DROP_COUNT_BIT_WIDTH-1:0] drop_q;

`ifdef BTLE_RX_PDU_READER_CRC_FILTER_EN
  assign crc_reject = ~crc_ok;
`else
  assign crc_reject = 1'b0;
`endif

  always_comb begin
    len_info   = clamp_len(payload_length);
    pop        = m_valid & m_ready;
    // Occupancy after this cycle's pop: counting the pop lets a new read go
    // out every cycle while the consumer keeps up, without overfilling.
    occ_eff    = fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
    issue      = (state_q == STREAM) && (rd_ptr_p0 < total_q) && (occ_eff < 2'd2);
    last_issue = (rd_ptr_p0 == total_q - CNT_W'(1));
    done       = pop & m_last;
    accept     = (state_q == IDLE) & decode_end & ~crc_reject;
    // A decode_end while busy (including the final-handshake cycle) is dropped.
    drop       = decode_end & ((state_q == STREAM) | crc_reject);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_valid            = (fifo_cnt != 2'd0);
  assign m_octet            = fifo_data[rd_idx];
  assign m_last             = m_valid & fifo_last[rd_idx];
  assign m_crc_ok           = crc_q;
  assign m_truncated        = trunc_q;
  assign busy               = (state_q == STREAM);
  assign drop_count         = drop_q;
  // Address shows the read being issued; otherwise it holds the last one.
  assign pdu_octet_mem_addr = issue ? rd_ptr_p0[PDU_ADDR_BIT_WIDTH-1:0] : addr_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      total_q      <= '0;
      crc_q        <= 1'b0;
      trunc_q      <= 1'b0;
      rd_ptr_p0    <= '0;
      addr_hold    <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_idx       <= 1'b0;
      rd_idx       <= 1'b0;
      fifo_cnt     <= '0;
      drop_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        total_q   <= len_info[CNT_W-1:0];
        trunc_q   <= len_info[CNT_W];
        crc_q     <= crc_ok;
        rd_ptr_p0 <= '0;
      end
      if (drop) drop_q <= sat_inc(drop_q);

      // p0 -> p1: read issued this cycle, data returns next cycle
      if (issue) begin
        rd_ptr_p0 <= rd_ptr_p0 + CNT_W'(1);
        addr_hold <= rd_ptr_p0[PDU_ADDR_BIT_WIDTH-1:0];
      end
      if (done) begin
        rd_ptr_p0 <= '0;
        addr_hold <= '0;
      end
      vld_p1  <= issue;
      last_p1 <= issue & last_issue;

      // p1 -> FIFO: returning octet is pushed; head pops on handshake
      if (vld_p1) begin
        fifo_data[wr_idx] <= pdu_octet_mem_data;
        fifo_last[wr_idx] <= last_p1;
        wr_idx            <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      fifo_cnt <= occ_eff;
    end
  end

endmodule

// File: tb/tb_btle_rx_pdu_reader.sv
module tb_btle_rx_pdu_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       decode_end;
  logic       crc_ok;
  logic [6:0] payload_length;
  logic [5:0] pdu_octet_mem_addr;
  logic [7:0] pdu_octet_mem_data;
  logic [7:0] m_octet;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       m_crc_ok;
  logic       m_truncated;
  logic       busy;
  logic [7:0] drop_count;

  typedef struct packed {
    logic [7:0] oct;
    logic       last;
    logic       crc;
    logic       trunc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   hs_count = 0;
  int   cyc = 0;
  bit   rate_chk = 0;
  bit   pat_en = 0;
  bit   rdy_level = 1;
  bit   pat_arr [6] = '{1, 0, 0, 1, 0, 1};
  logic [7:0] mem [64];

  btle_rx_pdu_reader dut (
    .clk(clk), .rst(rst), .decode_end(decode_end), .crc_ok(crc_ok),
    .payload_length(payload_length), .pdu_octet_mem_addr(pdu_octet_mem_addr),
    .pdu_octet_mem_data(pdu_octet_mem_data), .m_octet(m_octet), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .m_crc_ok(m_crc_ok),
    .m_truncated(m_truncated), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Registered-read PDU memory model
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    pdu_octet_mem_data = 8'h00;
    forever begin
      @(posedge clk);
      pdu_octet_mem_data <= mem[pdu_octet_mem_addr];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready driver: fixed level or repeating 1,0,0,1,0,1 pattern
  initial begin
    int pi;
    pi = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pat_en) begin
        m_ready = pat_arr[pi];
        pi = (pi + 1) % 6;
      end else begin
        m_ready = rdy_level;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  initial begin
    bit         stall_pend;
    logic [7:0] stall_oct;
    logic       stall_last;
    int         prev_cyc;
    bit         prev_last;
    exp_t       e;
    stall_pend = 0;
    prev_last  = 1;
    prev_cyc   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 0;
        prev_last  = 1;
      end else begin
        if (stall_pend)
          check("stall_hold", {m_valid, m_last, m_octet}, {1'b1, stall_last, stall_oct});
        if (m_valid && m_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_octet: got %0h, expected no output", m_octet);
          end else begin
            e = exp_q.pop_front();
            check("octet{oct,last,crc,trunc}", {m_octet, m_last, m_crc_ok, m_truncated}, e);
          end
          if (rate_chk && !prev_last)
            check("full_rate_gap", cyc - prev_cyc, 1);
          prev_cyc  = cyc;
          prev_last = m_last;
        end
        stall_pend = m_valid && !m_ready;
        stall_oct  = m_octet;
        stall_last = m_last;
      end
    end
  end

  task automatic pulse(input int plen, input logic crc, input bit expect_stream);
    int   total;
    logic tr;
    total = plen + 2;
    tr    = 1'b0;
    if (total > 64) begin
      total = 64;
      tr    = 1'b1;
    end
    if (expect_stream)
      for (int i = 0; i < total; i++)
        exp_q.push_back('{8'(i), (i == total - 1), crc, tr});
    @(posedge clk);
    #1;
    decode_end     = 1'b1;
    crc_ok         = crc;
    payload_length = 7'(plen);
    @(posedge clk);
    #1;
    decode_end = 1'b0;
    crc_ok     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    check({name, "_completed"}, ok, 1);
  endtask

  initial begin
    bit reached;
    int hs_base;
    rst = 1'b1;
    decode_end = 1'b0;
    crc_ok = 1'b0;
    payload_length = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", pdu_octet_mem_addr, 0);
    check("rst_octet", m_octet, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_crc", m_crc_ok, 0);
    check("rst_trunc", m_truncated, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic stream at full rate with latency check
    rate_chk = 1;
    pulse(4, 1'b1, 1);
    check("busy_after_accept", busy, 1);
    @(negedge clk); check("lat_cycle1_valid", m_valid, 0);
    @(negedge clk); check("lat_cycle2_valid", m_valid, 0);
    @(negedge clk); check("lat_cycle3_valid", m_valid, 1);
    wait_done("basic", 40);
    rate_chk = 0;
    check("basic_addr_idle", pdu_octet_mem_addr, 0);

    // Backpressure pattern
    pat_en = 1;
    pulse(3, 1'b1, 1);
    wait_done("backpressure", 60);
    pat_en = 0;
    @(posedge clk);

    // Truncation to memory depth
    pulse(100, 1'b1, 1);
    wait_done("truncation", 200);
    check("trunc_flag_latched", m_truncated, 1);

    // Overrun during a 12-octet PDU
    pulse(10, 1'b1, 1);
    repeat (2) @(posedge clk);
    pulse(10, 1'b1, 0);
    check("overrun_busy", busy, 1);
    wait_done("overrun", 60);
    check("overrun_drop", drop_count, 1);

    // Saturation: hold a PDU stalled and fire 300 overruns
    rdy_level = 0;
    @(posedge clk);
    #2;
    pulse(0, 1'b1, 1);
    for (int i = 1; i <= 300; i++) begin
      pulse(0, 1'b1, 0);
      if (i == 253) check("drop_254", drop_count, 254);
      if (i == 254) check("drop_255", drop_count, 255);
    end
    check("drop_saturated", drop_count, 255);
    rdy_level = 1;
    wait_done("saturation_drain", 40);

    // Reset mid-stream after 3 octets of a 20-octet PDU
    pulse(18, 1'b1, 1);
    hs_base = hs_count;
    reached = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (hs_count - hs_base >= 3) begin
        reached = 1;
        break;
      end
    end
    check("midrst_3_octets_seen", reached, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_last", m_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_drop", drop_count, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    pulse(0, 1'b1, 1);
    wait_done("post_reset", 20);

    // CRC-bad PDU
`ifdef BTLE_RX_PDU_READER_CRC_FILTER_EN
    pulse(2, 1'b0, 0);
    repeat (6) @(negedge clk);
    #1;
    check("crcfilt_busy", busy, 0);
    check("crcfilt_valid", m_valid, 0);
    check("crcfilt_drop", drop_count, 1);
`else
    pulse(2, 1'b0, 1);
    wait_done("crc_bad_stream", 30);
    check("crc_bad_drop", drop_count, 0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
